// File: rtl/perceptron_comm_pkg.sv
// Shared constants and types for the perceptron byte protocol.
// Host master and its tx handshake import this package.
package perceptron_comm_pkg;

    localparam logic [7:0] OPC_READ          = 8'd5;
    localparam logic [7:0] OPC_WRITE_WEIGHTS = 8'd50;
    localparam logic [7:0] OPC_WRITE_INPUTS  = 8'd51;
    localparam logic [7:0] OPC_RSP_WEIGHTS   = 8'd100;
    localparam logic [7:0] OPC_RSP_INPUTS    = 8'd101;
    localparam logic [7:0] OPC_RSP_READ      = 8'd102;

    localparam int WR_FRAME_LEN = 5;
    localparam int RD_FRAME_LEN = 1;
    localparam int RD_REPLY_LEN = 6;

    typedef enum logic [1:0] {
        CMD_WR_WEIGHTS = 2'd0,
        CMD_WR_INPUTS  = 2'd1,
        CMD_READ       = 2'd2,
        CMD_RSVD       = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX_WAIT,
        ST_RX_CLR,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_LOAD,
        HS_WAIT_HI,
        HS_WAIT_LO
    } hs_state_e;

endpackage

// File: rtl/perceptron_host_master_uart_tx_handshake.sv
// Per-byte UART transmit handshake: load, wait busy high, wait busy low.
// byte_done_o pulses once the transmitter has gone idle again.
module uart_tx_handshake
    import perceptron_comm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_i,
    input  logic       go_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_byte_o,
    output logic       tx_send_o,
    output logic       byte_done_o
);

    hs_state_e  state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       send_q, send_d;

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        send_d      = 1'b0;
        byte_done_o = 1'b0;
        unique case (state_q)
            HS_IDLE: begin
                if (go_i) begin
                    state_d = HS_LOAD;
                end
            end
            HS_LOAD: begin
                if (!tx_busy_i) begin
                    byte_d  = byte_i;
                    send_d  = 1'b1;
                    state_d = HS_WAIT_HI;
                end
            end
            HS_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = HS_WAIT_LO;
                end
            end
            HS_WAIT_LO: begin
                if (!tx_busy_i) begin
                    byte_done_o = 1'b1;
                    state_d     = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HS_IDLE;
            byte_q  <= 8'h00;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            send_q  <= send_d;
        end
    end

    assign tx_byte_o = byte_q;
    assign tx_send_o = send_q;

endmodule

// File: rtl/perceptron_host_master.sv
// Host-side initiator: turns one command into a UART byte frame
// and, for reads, assembles the 6-byte reply.
module perceptron_host_master
    import perceptron_comm_pkg::*;
#(
    parameter int         CLK_FREQ          = 12000000,
    parameter int         RX_TIMEOUT_CYCLES = CLK_FREQ / 120,
    parameter logic [7:0] OP_READ           = OPC_READ,
    parameter logic [7:0] OP_WRITE_WEIGHTS  = OPC_WRITE_WEIGHTS,
    parameter logic [7:0] OP_WRITE_INPUTS   = OPC_WRITE_INPUTS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] wdata1,
    input  logic [15:0] wdata2,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_busy,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        rx_clear,
    output logic [15:0] rd_weight1,
    output logic [15:0] rd_weight2,
    output logic [15:0] rd_result,
    output logic        rd_valid,
    output logic        done,
    output logic        err
);

    localparam int TMO_W =
        (RX_TIMEOUT_CYCLES > 1) ? $clog2(RX_TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(RX_TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [15:0]        w1_q, w1_d;
    logic [15:0]        w2_q, w2_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [47:0]        shift_q, shift_d;
    logic               go_q, go_d;
    logic               clr_q, clr_d;
    logic               err_q, err_d;
    logic               rdv_q, rdv_d;
    logic [15:0]        rw1_q, rw1_d;
    logic [15:0]        rw2_q, rw2_d;
    logic [15:0]        rres_q, rres_d;

    logic [7:0] op;
    logic [7:0] frame_byte;
    logic       last_tx;
    logic       byte_done;

    always_comb begin
        op = OP_WRITE_WEIGHTS;
        if (cmd_q == CMD_WR_INPUTS) begin
            op = OP_WRITE_INPUTS;
        end else if (cmd_q == CMD_READ) begin
            op = OP_READ;
        end
    end

    always_comb begin
        frame_byte = 8'h00;
        unique case (cnt_q)
            3'd0:    frame_byte = op;
            3'd1:    frame_byte = w1_q[15:8];
            3'd2:    frame_byte = w1_q[7:0];
            3'd3:    frame_byte = w2_q[15:8];
            3'd4:    frame_byte = w2_q[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    assign last_tx = (cmd_q == CMD_READ)
        ? (cnt_q == 3'(RD_FRAME_LEN - 1))
        : (cnt_q == 3'(WR_FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        shift_d = shift_q;
        go_d    = 1'b0;
        clr_d   = 1'b0;
        err_d   = 1'b0;
        rdv_d   = 1'b0;
        rw1_d   = rw1_q;
        rw2_d   = rw2_q;
        rres_d  = rres_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd_e'(cmd);
                    w1_d  = wdata1;
                    w2_d  = wdata2;
                    cnt_d = 3'd0;
                    tmo_d = '0;
                    if (cmd == CMD_RSVD) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        go_d    = 1'b1;
                        state_d = ST_TX;
                    end
                end
            end
            ST_TX: begin
                if (byte_done) begin
                    if (!last_tx) begin
                        cnt_d = cnt_q + 3'd1;
                        go_d  = 1'b1;
                    end else if (cmd_q == CMD_READ) begin
                        cnt_d   = 3'd0;
                        tmo_d   = '0;
                        state_d = ST_RX_WAIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RX_WAIT: begin
                if (rx_ready) begin
                    shift_d = {shift_q[39:0], rx_byte};
                    clr_d   = 1'b1;
                    state_d = ST_RX_CLR;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RX_CLR: begin
                // Hold until the receiver drops ready so a byte is taken once.
                if (!rx_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    tmo_d = '0;
                    if (cnt_q == 3'(RD_REPLY_LEN - 1)) begin
                        rw1_d   = shift_q[47:32];
                        rw2_d   = shift_q[31:16];
                        rres_d  = shift_q[15:0];
                        rdv_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RX_WAIT;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_WR_WEIGHTS;
            w1_q    <= 16'h0000;
            w2_q    <= 16'h0000;
            cnt_q   <= 3'd0;
            tmo_q   <= '0;
            shift_q <= 48'h0;
            go_q    <= 1'b0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rw1_q   <= 16'h0000;
            rw2_q   <= 16'h0000;
            rres_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            shift_q <= shift_d;
            go_q    <= go_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
            rw1_q   <= rw1_d;
            rw2_q   <= rw2_d;
            rres_q  <= rres_d;
        end
    end

    uart_tx_handshake u_tx_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_i      (frame_byte),
        .go_i        (go_q),
        .tx_busy_i   (tx_busy),
        .tx_byte_o   (tx_byte),
        .tx_send_o   (tx_send),
        .byte_done_o (byte_done)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign rd_valid   = rdv_q;
    assign rx_clear   = clr_q;
    assign rd_weight1 = rw1_q;
    assign rd_weight2 = rw2_q;
    assign rd_result  = rres_q;

endmodule

// File: tb/tb_perceptron_host_master.sv
// Scoreboard bench for perceptron_host_master with UART tx/rx models.
module tb_perceptron_host_master;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] wdata1 = 16'h0;
    logic [15:0] wdata2 = 16'h0;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_byte = 8'h0;
    logic        rx_ready = 1'b0;
    logic        rx_clear;
    logic [15:0] rd_weight1;
    logic [15:0] rd_weight2;
    logic [15:0] rd_result;
    logic        rd_valid;
    logic        done;
    logic        err;

    perceptron_host_master #(
        .RX_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .wdata1     (wdata1),
        .wdata2     (wdata2),
        .tx_byte    (tx_byte),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .rx_clear   (rx_clear),
        .rd_weight1 (rd_weight1),
        .rd_weight2 (rd_weight2),
        .rd_result  (rd_result),
        .rd_valid   (rd_valid),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic        err;
        logic        rdv;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] res;
        int          nclr;
        logic        tmo;
    } ev_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] tx_q[$];
    ev_t        ev_q[$];
    logic [7:0] rx_q[$];

    logic [15:0] m_w1 = 16'h0;
    logic [15:0] m_w2 = 16'h0;
    logic [15:0] m_res = 16'h0;

    int   busy_len = 1;
    logic busy_imm = 1'b0;
    logic spurious = 1'b0;
    logic real_hold = 1'b0;
    int   gap = 0;

    int   done_cnt = 0;
    int   send_cnt = 0;
    int   clr_cnt = 0;
    int   last_clr_cyc = 0;
    int   acc_cyc = 0;
    logic first_pend = 1'b0;
    logic in_txn = 1'b0;
    logic ready_bad = 1'b0;
    logic ready_chk = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model: busy rises after a strobe and stays up busy_len cycles.
    initial forever begin
        @(negedge clk);
        if (tx_send) begin
            if (!busy_imm) @(negedge clk);
            tx_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    // Receiver model: presents queued bytes, holds ready until rx_clear.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rx_ready  = 1'b0;
            real_hold = 1'b0;
        end else if (rx_ready && rx_clear) begin
            rx_ready  = 1'b0;
            real_hold = 1'b0;
            gap = $urandom_range(0, 5);
        end else if (!rx_ready && rx_q.size() > 0) begin
            if (gap > 0) begin
                gap--;
            end else begin
                rx_byte   = rx_q.pop_front();
                rx_ready  = 1'b1;
                real_hold = 1'b1;
            end
        end else if (!real_hold) begin
            rx_ready = spurious;
            if (spurious) rx_byte = 8'hA5;
        end
    end

    logic [7:0] exp8;
    ev_t        mev;
    int         dly;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ready_chk) begin
                check("cmd_ready_after_done", 64'(cmd_ready), 1);
                ready_chk = 1'b0;
            end
            if (in_txn && cmd_ready && !done) ready_bad = 1'b1;
            if (rx_clear) begin
                clr_cnt++;
                last_clr_cyc = cyc;
            end
            if (tx_send) begin
                send_cnt++;
                if (first_pend) begin
                    check("accept_to_send", 64'(cyc - acc_cyc), 2);
                    first_pend = 1'b0;
                end
                if (tx_q.size() == 0) begin
                    check("unexpected_tx_send", 64'(tx_byte), 64'hFFFF);
                end else begin
                    exp8 = tx_q.pop_front();
                    check("tx_byte", 64'(tx_byte), 64'(exp8));
                end
            end
            if ((err || rd_valid) && !done) begin
                check("err_rdv_without_done", 64'({err, rd_valid}), 0);
            end
            if (done) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mev = ev_q.pop_front();
                    check("err", 64'(err), 64'(mev.err));
                    check("rd_valid", 64'(rd_valid), 64'(mev.rdv));
                    check("rd_weight1", 64'(rd_weight1), 64'(mev.w1));
                    check("rd_weight2", 64'(rd_weight2), 64'(mev.w2));
                    check("rd_result", 64'(rd_result), 64'(mev.res));
                    check("rx_clear_count", 64'(clr_cnt), 64'(mev.nclr));
                    check("tx_bytes_left", 64'(tx_q.size()), 0);
                    check("cmd_ready_low_in_txn", 64'(ready_bad), 0);
                    if (mev.tmo) begin
                        dly = cyc - last_clr_cyc;
                        check("timeout_delay", 64'(dly >= TMO && dly <= TMO + 3), 1);
                    end
                end
                clr_cnt   = 0;
                ready_bad = 1'b0;
                in_txn    = 1'b0;
                ready_chk = 1'b1;
                done_cnt++;
            end
        end
    end

    task automatic issue_start(input logic [1:0] c, input logic [15:0] a,
                               input logic [15:0] b, input logic [7:0] rb[6],
                               input int nrx, input int blen,
                               input logic imm, input logic spur);
        ev_t e;
        int  t;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        busy_len = blen;
        busy_imm = imm;
        spurious = spur;
        e.err  = 1'b0;
        e.rdv  = 1'b0;
        e.nclr = 0;
        e.tmo  = 1'b0;
        if (c == 2'd0 || c == 2'd1) begin
            tx_q.push_back(c == 2'd0 ? 8'd50 : 8'd51);
            tx_q.push_back(a[15:8]);
            tx_q.push_back(a[7:0]);
            tx_q.push_back(b[15:8]);
            tx_q.push_back(b[7:0]);
        end else if (c == 2'd2) begin
            tx_q.push_back(8'd5);
            for (int i = 0; i < nrx; i++) rx_q.push_back(rb[i]);
            e.nclr = nrx;
            if (nrx == 6) begin
                m_w1  = {rb[0], rb[1]};
                m_w2  = {rb[2], rb[3]};
                m_res = {rb[4], rb[5]};
                e.rdv = 1'b1;
            end else begin
                e.err = 1'b1;
                e.tmo = 1'b1;
            end
        end else begin
            e.err = 1'b1;
        end
        e.w1  = m_w1;
        e.w2  = m_w2;
        e.res = m_res;
        ev_q.push_back(e);
        cmd       = c;
        wdata1    = a;
        wdata2    = b;
        cmd_valid = 1'b1;
        first_pend = (c != 2'd3) && !tx_busy;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        in_txn    = 1'b1;
    endtask

    task automatic wait_done(input int pre);
        int t;
        t = 0;
        while (done_cnt == pre && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == pre) check("done_timeout", 0, 1);
        spurious = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] rb[6],
                         input int nrx, input int blen,
                         input logic imm, input logic spur);
        int pre;
        pre = done_cnt;
        issue_start(c, a, b, rb, nrx, blen, imm, spur);
        wait_done(pre);
    endtask

    logic [7:0] rb[6];
    logic [1:0] rc;
    int         base;
    int         t;

    initial begin
        for (int i = 0; i < 6; i++) rb[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 1);
        check("rst_tx_send", 64'(tx_send), 0);
        check("rst_tx_byte", 64'(tx_byte), 0);
        check("rst_rx_clear", 64'(rx_clear), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_rd_valid", 64'(rd_valid), 0);
        check("rst_rd_w1", 64'(rd_weight1), 0);
        check("rst_rd_w2", 64'(rd_weight2), 0);
        check("rst_rd_res", 64'(rd_result), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(2'd0, 16'h0102, 16'h0304, rb, 0, 1250, 1'b0, 1'b0);
        issue(2'd1, 16'd70, 16'd71, rb, 0, 8, 1'b1, 1'b1);
        rb[0] = 8'd0; rb[1] = 8'd101; rb[2] = 8'd0;
        rb[3] = 8'd102; rb[4] = 8'd0; rb[5] = 8'd103;
        issue(2'd2, 16'h0, 16'h0, rb, 6, 4, 1'b0, 1'b0);
        rb[0] = 8'd9; rb[1] = 8'd8; rb[2] = 8'd7;
        issue(2'd2, 16'h0, 16'h0, rb, 3, 4, 1'b1, 1'b0);
        issue(2'd3, 16'hFFFF, 16'hFFFF, rb, 0, 4, 1'b0, 1'b0);

        base = send_cnt;
        issue_start(2'd0, 16'hBEEF, 16'hCAFE, rb, 0, 30, 1'b0, 1'b0);
        t = 0;
        while (send_cnt < base + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reached_byte2", 64'(send_cnt - base), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", 64'(cmd_ready), 1);
        check("arst_tx_send", 64'(tx_send), 0);
        check("arst_tx_byte", 64'(tx_byte), 0);
        check("arst_done", 64'(done), 0);
        check("arst_err", 64'(err), 0);
        check("arst_rd_w1", 64'(rd_weight1), 0);
        check("arst_rd_res", 64'(rd_result), 0);
        tx_q.delete();
        ev_q.delete();
        rx_q.delete();
        m_w1 = 16'h0;
        m_w2 = 16'h0;
        m_res = 16'h0;
        in_txn = 1'b0;
        first_pend = 1'b0;
        ready_bad = 1'b0;
        repeat (3) @(negedge clk);
        clr_cnt = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(2'd0, 16'h1234, 16'h5678, rb, 0, 6, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            rc = 2'($urandom_range(0, 3));
            for (int k = 0; k < 6; k++) rb[k] = 8'($urandom);
            issue(rc, 16'($urandom), 16'($urandom), rb,
                  ($urandom_range(0, 3) == 0) ? 3 : 6,
                  $urandom_range(1, 20), 1'($urandom_range(0, 1)),
                  (rc < 2'd2) && ($urandom_range(0, 1) == 1));
        end

        check("final_tx_queue_empty", 64'(tx_q.size()), 0);
        check("final_ev_queue_empty", 64'(ev_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_host_master.md
Name: perceptron_host_master

Overview:
- Host-side initiator for the perceptron byte protocol. It turns a single command request (write weights, write inputs, or read back) into the UART byte sequence the perceptron comm controller expects.
- For reads, it collects the 6-byte reply.
- Sits between a UART tx/rx pair and either a test sequencer or a second FPGA's control logic.

Parameters:
- CLK_FREQ, 12000000, clock frequency in Hz; used only to derive the timeout.
- RX_TIMEOUT_CYCLES, 100000, maximum cycles to wait for each reply byte before aborting.
- OP_READ, 5, read opcode byte.
- OP_WRITE_WEIGHTS, 50, write-weights opcode byte.
- OP_WRITE_INPUTS, 51, write-inputs opcode byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  2  command: 0 = write weights, 1 = write inputs, 2 = read, 3 = reserved
- cmd_valid  in  1  command request; sampled only when cmd_ready = 1
- cmd_ready  out  1  high in IDLE
- wdata1  in  16  first operand (weight1 or input1); captured on accept
- wdata2  in  16  second operand (weight2 or input2); captured on accept
- tx_byte  out  8  byte to UART transmitter
- tx_send  out  1  one-cycle send strobe
- tx_busy  in  1  UART transmitter busy
- rx_byte  in  8  byte from UART receiver
- rx_ready  in  1  received byte available (level)
- rx_clear  out  1  one-cycle acknowledge of rx byte
- rd_weight1  out  16  read-back weight1
- rd_weight2  out  16  read-back weight2
- rd_result  out  16  read-back result
- rd_valid  out  1  one-cycle pulse when all 6 read bytes are assembled
- done  out  1  one-cycle pulse at the end of any accepted command
- err  out  1  one-cycle pulse on timeout or reserved command; asserted in the same cycle as done

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all outputs 0 except cmd_ready = 1; byte counter 0; internal shift registers 0. Reset mid-transaction aborts immediately with no done pulse.
- Accept: in IDLE, when cmd_valid is high, latch cmd, wdata1 and wdata2, and drop cmd_ready on the next edge.
  - cmd = 3: go to DONE with err = 1. No bytes are sent.
- Tx frame:
  - Write commands send 5 bytes: opcode, wdata1[15:8], wdata1[7:0], wdata2[15:8], wdata2[7:0] (MSB first).
  - Read sends 1 byte: OP_READ.
- Tx handshake, per byte:
  - TX_LOAD: wait for tx_busy = 0, then drive tx_byte and pulse tx_send for exactly 1 cycle.
  - TX_WAIT_HI: wait for tx_busy = 1.
  - TX_WAIT_LO: wait for tx_busy = 0, then increment the byte counter.
  - tx_byte holds its value from the strobe until the next load.
  - If tx_busy is already 1 in the cycle tx_send asserts, TX_WAIT_HI exits on the next cycle.
- After the last tx byte:
  - Write commands go to DONE.
  - Read goes to RX_WAIT with the counter cleared.
- RX_WAIT:
  - Timeout counter counts up from 0.
  - When rx_ready = 1, shift rx_byte into a 48-bit register (MSB first: w1 hi, w1 lo, w2 hi, w2 lo, res hi, res lo), pulse rx_clear for 1 cycle, and enter RX_CLR.
  - If the counter reaches RX_TIMEOUT_CYCLES - 1 with no byte, go to DONE with err = 1. rd_* are not updated and rd_valid is not pulsed.
- RX_CLR: wait until rx_ready = 0 so one byte is never counted twice, then increment the counter and reset the timeout.
  - After the 6th byte, load rd_weight1, rd_weight2 and rd_result together, pulse rd_valid, and go to DONE.
- DONE: pulse done for 1 cycle, then go to IDLE.
- rd_* hold their value until the next successful read.
- Any rx_ready outside RX_WAIT/RX_CLR is ignored (no rx_clear).
- Latency: command accept to first tx_send is 2 cycles when tx_busy = 0.

Decomposition:
- Shared package perceptron_comm_pkg holds:
  - the opcode constants (5, 50, 51, 100, 101, 102);
  - the cmd encodings;
  - the state enumeration.
- The tx byte handshake (load / wait-high / wait-low) becomes sub-module uart_tx_handshake. It takes byte + go and returns byte_done.
- Everything else stays in this module.

Test Plan:
- cmd = 0, wdata1 = 16'h0102, wdata2 = 16'h0304; tx_busy model goes high 1 cycle after tx_send for 1250 cycles -> tx_byte sequence 50, 1, 2, 3, 4; exactly 5 tx_send pulses; done pulses once; err = 0.
- cmd = 1, wdata1 = 70, wdata2 = 71 -> bytes 51, 0, 70, 0, 71; cmd_ready low throughout and high the cycle after done.
- cmd = 2; rx model returns 0, 101, 0, 102, 0, 103 with rx_ready held until rx_clear -> 1 tx byte (5); 6 rx_clear pulses; rd_weight1 = 101, rd_weight2 = 102, rd_result = 103; rd_valid and done pulse together.
- cmd = 2, RX_TIMEOUT_CYCLES = 50; only 3 bytes returned -> err and done pulse about 50 cycles after the 3rd rx_clear; rd_* keep their previous values; rd_valid stays 0.
- cmd = 3 -> no tx_send; err and done pulse within 2 cycles.
- rst_n low while byte 2 of a write is in flight -> all outputs return to reset values asynchronously; after release, a new cmd = 0 transaction sends a full 5-byte frame from the opcode.
